// File: rtl/activation_pkg.sv
// Shared types and constants for the activation stream path: FSM encoding,
// default geometry and the credit counter width helper.
package activation_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } act_state_e;

  localparam int DEF_DAT_DW       = 16;
  localparam int DEF_TOUT         = 32;
  localparam int DEF_CREDIT_DEPTH = 16;

  // Enough bits to hold every value from 0 up to and including depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/act_credit_counter.sv
// Saturating credit counter: starts full, dec on consume, inc on return,
// sticky ovf when a credit comes back while already full.
module act_credit_counter
  import activation_pkg::*;
#(
  parameter int DEPTH = DEF_CREDIT_DEPTH,
  parameter int W     = credit_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec,
  input  logic         inc,
  input  logic         clr_ovf,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic inc_only, dec_only;
  assign inc_only = inc & ~dec;
  assign dec_only = dec & ~inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FULL;
      ovf <= 1'b0;
    end else begin
      // dec is only ever raised with cnt != 0, so no underflow guard here
      if (dec_only)
        cnt <= cnt - W'(1);
      else if (inc_only && cnt < FULL)
        cnt <= cnt + W'(1);

      if (inc_only && cnt == FULL)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/activation_stream_ctrl.sv
// Credit-gated read-response sequencer feeding the activation pipeline.
// Define ACT_STREAM_OUT_REG_EN to register the output beat (1-cycle latency).
module activation_stream_ctrl
  import activation_pkg::*;
#(
  parameter int DAT_DW       = DEF_DAT_DW,
  parameter int TOUT         = DEF_TOUT,
  parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       w_in,
  input  logic [CNT_W-1:0]       h_in,
  input  logic [CNT_W-1:0]       ch_div_tout,
  input  logic                   rd_resp_vld,
  output logic                   rd_resp_rdy,
  input  logic [DAT_DW*TOUT-1:0] rd_resp_pd,
  output logic                   rd_fifo_pop,
  input  logic                   credit_vld,
  output logic                   dat_out_vld,
  output logic [DAT_DW*TOUT-1:0] dat_out,
  output logic                   dat_out_last,
  output logic                   working,
  output logic                   done,
  output logic                   credit_ovf
);

  localparam int CW = credit_w(CREDIT_DEPTH);

  act_state_e       state, nxt;
  logic [CNT_W-1:0] w_cnt, h_cnt, ch_cnt;
  logic [CW-1:0]    credit_cnt;
  logic             w_max, h_max, ch_max, frame_last;
  logic             cfg_ok, start_acc, pop, fin_exit;

  assign cfg_ok     = (|w_in) & (|h_in) & (|ch_div_tout);
  assign start_acc  = (state == IDLE) & start;
  assign w_max      = (w_cnt  == w_in - CNT_W'(1));
  assign h_max      = (h_cnt  == h_in - CNT_W'(1));
  assign ch_max     = (ch_cnt == ch_div_tout - CNT_W'(1));
  assign frame_last = w_max & h_max & ch_max;

  assign rd_resp_rdy = (state == RUN) & (credit_cnt != '0);
  assign pop         = rd_resp_vld & rd_resp_rdy;
  assign rd_fifo_pop = pop;
  assign working     = (state == RUN);

  act_credit_counter #(.DEPTH(CREDIT_DEPTH), .W(CW)) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .dec     (pop),
    .inc     (credit_vld),
    .clr_ovf (start_acc),
    .cnt     (credit_cnt),
    .ovf     (credit_ovf)
  );

`ifdef ACT_STREAM_OUT_REG_EN
  // FIN lasts two cycles so done trails the registered last beat.
  logic fin_dly;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fin_dly <= 1'b0;
    else        fin_dly <= (state == FIN) & ~fin_dly;
  end
  assign fin_exit = fin_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_out_vld  <= 1'b0;
      dat_out_last <= 1'b0;
      dat_out      <= '0;
    end else begin
      dat_out_vld  <= pop;
      dat_out_last <= pop & frame_last;
      if (pop) dat_out <= rd_resp_pd;
    end
  end
`else
  assign fin_exit     = 1'b1;
  assign dat_out_vld  = pop;
  assign dat_out_last = pop & frame_last;
  assign dat_out      = rd_resp_pd;
`endif

  assign done = (state == FIN) & fin_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = cfg_ok ? RUN : FIN;
      RUN:  if (pop && frame_last) nxt = FIN;
      FIN:  if (fin_exit) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // width -> height -> channel-group walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt  <= '0;
      h_cnt  <= '0;
      ch_cnt <= '0;
    end else if (start_acc) begin
      w_cnt  <= '0;
      h_cnt  <= '0;
      ch_cnt <= '0;
    end else if (pop) begin
      if (w_max) begin
        w_cnt <= '0;
        if (h_max) begin
          h_cnt  <= '0;
          ch_cnt <= ch_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end else begin
        w_cnt <= w_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/activation_stream_ctrl.md
# activation_stream_ctrl

Parametrised, credit-gated read-response sequencer for the activation (GELU) path. It accepts Tout-wide response beats from the MCIF read FIFO only while downstream credits are available, and walks a width → height → channel-group loop over one frame. It forwards each beat to the activation pipeline with a last-of-frame marker and signals frame completion. It sits between the MCIF read-response FIFO and the activation datapath; credits are returned by the activation pipeline output stage.

## Interface
Parameters:
- DAT_DW, 16: bits per channel element
- TOUT, 32: channels per beat
- CREDIT_DEPTH, 16: initial/maximum credits (activation pipeline depth); ≥1
- CNT_W, 16: width of the w/h/channel-group counters and configuration inputs

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- w_in  in  CNT_W  beats per row
- h_in  in  CNT_W  rows per channel group
- ch_div_tout  in  CNT_W  channel groups (CH/Tout)
- rd_resp_vld  in  1  response beat valid
- rd_resp_rdy  out  1  response beat accepted this cycle if vld
- rd_resp_pd  in  DAT_DW*TOUT  response payload
- rd_fifo_pop  out  1  rd_resp_vld & rd_resp_rdy
- credit_vld  in  1  one credit returned
- dat_out_vld  out  1  beat valid to activation pipeline
- dat_out  out  DAT_DW*TOUT  beat payload
- dat_out_last  out  1  final beat of frame, qualified by dat_out_vld
- working  out  1  high in RUN
- done  out  1  one-cycle frame-complete pulse
- credit_ovf  out  1  sticky: credit returned while at CREDIT_DEPTH

## Operation
- FSM states: IDLE, RUN, FIN. Reset → IDLE.
- IDLE: start with w_in, h_in and ch_div_tout all nonzero → RUN and clear counters. start with any of them zero → FIN, with no beat consumed.
- RUN: pop = rd_resp_vld & (credit_cnt≠0). On pop, w_cnt increments and wraps at w_in−1. On w wrap, h_cnt increments and wraps at h_in−1. On h wrap, ch_cnt increments. A pop with all three counters at max → FIN.
- FIN: done=1 for one cycle → IDLE.
- start outside IDLE is ignored. Configuration inputs must be held stable from start to done.
- Credits: credit_cnt has width $clog2(CREDIT_DEPTH+1) and resets to CREDIT_DEPTH. Credits are not reset by start; they persist across frames.
  - Pop only: −1.
  - credit_vld only: +1 if credit_cnt<CREDIT_DEPTH; otherwise unchanged and credit_ovf set.
  - Pop and credit_vld in the same cycle: unchanged.
- credit_ovf clears on an accepted start.
- dat_out_last = pop with all counters at max.

## Timing
- rd_resp_rdy = (state==RUN) & (credit_cnt≠0). It is combinational, with no dependence on rd_resp_vld.
- Without the macro:
  - dat_out_vld = pop and dat_out = rd_resp_pd, both combinational with 0-cycle latency.
  - done is asserted the cycle after the last pop.
- Reset values: rd_resp_rdy=0, rd_fifo_pop=0, dat_out_vld=0, dat_out=0 (registered mode), dat_out_last=0, working=0, done=0, credit_ovf=0.
- Asserting rst_n low mid-frame returns the block to IDLE immediately. Counters are cleared and credits restored to CREDIT_DEPTH.
- Throughput is 1 beat/cycle while credits are greater than 0. With zero credits, a credit_vld in cycle N allows a pop in cycle N+1.

## Configuration
- ACT_STREAM_OUT_REG_EN defined:
  - dat_out, dat_out_vld and dat_out_last come from registers loaded on pop, giving 1-cycle latency.
  - dat_out holds its value when no pop occurs.
  - done is asserted in the cycle after the registered last beat, i.e. 2 cycles after the last pop. FIN is extended by one cycle for this.
- Undefined: combinational pass-through as described in Timing.

## Structure
- Shared package activation_pkg holds:
  - FSM state encoding (IDLE/RUN/FIN)
  - Default DAT_DW/TOUT/CREDIT_DEPTH constants
  - The credit-width function
- Sub-module act_credit_counter is natural: a saturating up/down counter with overflow flag, parametrised by DEPTH.
- The loop counters and FSM stay in the top module.

## Test plan
- w=4, h=2, ch=3, vld always high, no credit returns, CREDIT_DEPTH=16 → exactly 16 pops, then rdy=0. Return 8 credits → 8 more pops. dat_out_last on pop #24; done the next cycle.
- Same frame with credit_vld every cycle → 24 back-to-back pops, credit_cnt constant at 16, done at cycle 25 after first pop.
- Zero dimension, h_in=0 → no pops, FIN then done one cycle after start, working stays 0.
- credit_vld while credit_cnt=16 → credit_cnt stays 16, credit_ovf=1 until the next accepted start.
- rst_n asserted mid-frame (after 5 of 24 pops) → all outputs at reset values. A new start runs a full 24-beat frame with 16 credits.
- With ACT_STREAM_OUT_REG_EN: dat_out equals rd_resp_pd from the previous cycle on every pop. dat_out_last one cycle after the last pop; done 2 cycles after it.
